// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: steers a bank of WIDTH JK flops to a requested target word.
// A target is accepted in IDLE and J/K are computed per bit from the excitation
// table of (q_fb, target). They are driven for one DRIVE cycle, and q_fb is then
// compared with the target in CHECK. A mismatch triggers a re-drive from the
// current q_fb, up to MAX_RETRY extra attempts. After that the block reports err.
// Optional build macro JK_TOGGLE_PREF_EN: changing bits use toggle encoding
// (J=K=1) instead of the default set/reset encoding.
module jk_excitation_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // J for each bit, given current state q and desired next state t.
    function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_PREF_EN
        return q ^ t;
`else
        return t & ~q;
`endif
    endfunction

    // K for each bit; don't-care entries resolve to 0 (hold).
    function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_PREF_EN
        return q ^ t;
`else
        return q & ~t;
`endif
    endfunction

    // Next-state and next-output logic of the IDLE/DRIVE/CHECK controller.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        retry_d = retry_q;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    j_d     = excite_j(q_fb, tgt_data);
                    k_d     = excite_k(q_fb, tgt_data);
                    retry_d = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                // J/K fall back to 0 so the bank holds while it is checked.
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + RW'(1);
                    j_d     = excite_j(q_fb, tgt_q);
                    k_d     = excite_k(q_fb, tgt_q);
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register controller state and all outputs; reset abandons any transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            retry_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            retry_q <= retry_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign j_out     = j_q;
    assign k_out     = k_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Testbench for jk_excitation_driver: a JK flop bank model (with optional
// stuck-at-0 bits) closes the loop. The expected output sequence of each
// transfer is planned into a queue when the target is accepted, and it is
// compared against the DUT on every cycle. Directed literal checks come first,
// followed by randomized traffic.
module tb_jk_excitation_driver;

    localparam int W  = 4;
    localparam int MR = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         tgt_valid;
    logic         tgt_ready;
    logic [W-1:0] tgt_data;
    logic [W-1:0] j_out, k_out;
    logic         busy, done, err;
    logic [W-1:0] q_bank = '0;
    logic [W-1:0] stuck0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    jk_excitation_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clock     (clock),
        .reset     (reset),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .q_fb      (q_bank),
        .j_out     (j_out),
        .k_out     (k_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic         ready;
        logic         busy;
        logic         done;
        logic         err;
        logic [W-1:0] j;
        logic [W-1:0] k;
    } obs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // JK flop bank behaviour: 00 hold, 01 reset, 10 set, 11 toggle; stuck bits read 0.
    function automatic logic [W-1:0] bank_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                               input logic [W-1:0] k, input logic [W-1:0] stuck);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            case ({j[i], k[i]})
                2'b00:   r[i] = q[i];
                2'b01:   r[i] = 1'b0;
                2'b10:   r[i] = 1'b1;
                default: r[i] = ~q[i];
            endcase
        end
        return r & ~stuck;
    endfunction

    always @(posedge clock) q_bank <= bank_next(q_bank, j_out, k_out, stuck0);

    // Excitation table lookup: returns {J, K}.
    function automatic logic [2*W-1:0] excite(input logic [W-1:0] q, input logic [W-1:0] t);
        logic [W-1:0] j, k;
        j = '0;
        k = '0;
        for (int i = 0; i < W; i++) begin
            case ({q[i], t[i]})
`ifdef JK_TOGGLE_PREF_EN
                2'b01, 2'b10: begin j[i] = 1'b1; k[i] = 1'b1; end
`else
                2'b01: j[i] = 1'b1;
                2'b10: k[i] = 1'b1;
`endif
                default: ;
            endcase
        end
        return {j, k};
    endfunction

    function automatic obs_t mk(input logic r, input logic b, input logic d, input logic e,
                                input logic [2*W-1:0] jk);
        obs_t o;
        o.ready = r;
        o.busy  = b;
        o.done  = d;
        o.err   = e;
        o.j     = jk[2*W-1:W];
        o.k     = jk[W-1:0];
        return o;
    endfunction

    obs_t exp_q[$];
    obs_t exp_cur;
    bit   model_on = 0;

    // Plan the full cycle-by-cycle output sequence of one transfer.
    task automatic plan(input logic [W-1:0] q0, input logic [W-1:0] t, input logic [W-1:0] stuck);
        logic [W-1:0]   q;
        logic [2*W-1:0] jk;
        q = q0;
        for (int n = 0; n <= MR; n++) begin
            jk = excite(q, t);
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, jk));
            q = bank_next(q, jk[2*W-1:W], jk[W-1:0], stuck);
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, '0));
            if (q == t) begin
                exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, '0));
                return;
            end
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, '0));
    endtask

    // Model advance at each active edge.
    always @(posedge clock) begin
        if (reset) begin
            exp_q.delete();
            exp_cur  = mk(1'b1, 1'b0, 1'b0, 1'b0, '0);
            model_on = 1;
        end else if (model_on) begin
            if (exp_cur.ready && tgt_valid) begin
                exp_q.delete();
                plan(q_bank, tgt_data, stuck0);
            end
            if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
            else                  exp_cur = mk(1'b1, 1'b0, 1'b0, 1'b0, '0);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (model_on) begin
            check("cycle_obs", 32'({tgt_ready, busy, done, err, j_out, k_out}), 32'(exp_cur));
        end
    end

    initial begin
        reset     = 1'b1;
        tgt_valid = 1'b0;
        tgt_data  = '0;
        stuck0    = '0;

        // Pin the excitation model to hand-computed values.
`ifdef JK_TOGGLE_PREF_EN
        check("model_exc_a", 32'(excite(4'b1010, 4'b0110)), 32'h0000_00CC);
`else
        check("model_exc_a", 32'(excite(4'b1010, 4'b0110)), 32'h0000_0048);
`endif
        check("model_exc_b", 32'(excite(4'b0110, 4'b0110)), 32'h0);
        check("model_bank", 32'(bank_next(4'b0110, 4'b0001, 4'b0110, 4'b0001)), 32'h0);

        repeat (2) @(negedge clock);
        check("rst_ready", 32'(tgt_ready), 32'd1);
        check("rst_outs", 32'({busy, done, err, j_out, k_out}), 32'd0);

        // 0000 -> 1010
        reset = 1'b0; tgt_valid = 1'b1; tgt_data = 4'b1010;
        @(negedge clock); tgt_valid = 1'b0;
        check("s1_drive_j", 32'(j_out), 32'(4'b1010));
`ifdef JK_TOGGLE_PREF_EN
        check("s1_drive_k", 32'(k_out), 32'(4'b1010));
`else
        check("s1_drive_k", 32'(k_out), 32'(4'b0000));
`endif
        check("s1_drive_busy", 32'({busy, tgt_ready}), 32'(2'b10));
        @(negedge clock);
        check("s1_check_q", 32'(q_bank), 32'(4'b1010));
        check("s1_check_jk", 32'({j_out, k_out}), 32'd0);
        @(negedge clock);
        check("s1_done", 32'({done, err}), 32'(2'b10));

        // 1010 -> 0110, accepted in the done cycle
        tgt_valid = 1'b1; tgt_data = 4'b0110;
        @(negedge clock); tgt_valid = 1'b0;
`ifdef JK_TOGGLE_PREF_EN
        check("s2_jk", 32'({j_out, k_out}), 32'(8'b1100_1100));
`else
        check("s2_jk", 32'({j_out, k_out}), 32'(8'b0100_1000));
`endif
        @(negedge clock);
        @(negedge clock);
        check("s2_done", 32'({done, err, q_bank}), 32'(6'b10_0110));

        // target equals current state
        tgt_valid = 1'b1; tgt_data = 4'b0110;
        @(negedge clock); tgt_valid = 1'b0;
        check("s3_jk", 32'({busy, j_out, k_out}), 32'(9'b1_0000_0000));
        @(negedge clock);
        @(negedge clock);
        check("s3_done", 32'({done, err}), 32'(2'b10));

        // bit0 stuck at 0: three drives then err
        stuck0 = 4'b0001; tgt_valid = 1'b1; tgt_data = 4'b0001;
        @(negedge clock); tgt_valid = 1'b0;
`ifdef JK_TOGGLE_PREF_EN
        check("s4_drive1_j", 32'(j_out), 32'(4'b0111));
`else
        check("s4_drive1_j", 32'(j_out), 32'(4'b0001));
`endif
        @(negedge clock);
        @(negedge clock);
        check("s4_drive2_j", 32'({busy, j_out}), 32'(5'b1_0001));
        @(negedge clock);
        @(negedge clock);
        check("s4_drive3_j", 32'({busy, j_out}), 32'(5'b1_0001));
        @(negedge clock);
        check("s4_check3", 32'({busy, done, err}), 32'(3'b100));
        @(negedge clock);
        check("s4_err", 32'({done, err, tgt_ready}), 32'(3'b011));
        stuck0 = '0;

        // new word held during a transfer is taken only in the done cycle
        tgt_valid = 1'b1; tgt_data = 4'b1111;
        @(negedge clock); tgt_data = 4'b0101;
        check("s5_not_ready", 32'(tgt_ready), 32'd0);
        @(negedge clock);
        @(negedge clock);
        check("s5_done_ready", 32'({done, tgt_ready}), 32'(2'b11));
        @(negedge clock); tgt_valid = 1'b0;
`ifdef JK_TOGGLE_PREF_EN
        check("s5_second_jk", 32'({busy, j_out, k_out}), 32'(9'b1_1010_1010));
`else
        check("s5_second_jk", 32'({busy, j_out, k_out}), 32'(9'b1_0000_1010));
`endif
        @(negedge clock);
        @(negedge clock);
        check("s5_second_done", 32'({done, q_bank}), 32'(5'b1_0101));

        // reset during CHECK
        tgt_valid = 1'b1; tgt_data = 4'b0000;
        @(negedge clock); tgt_valid = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        check("s6_after_rst", 32'({tgt_ready, busy, done, err, j_out, k_out}), 32'(12'b1000_0000_0000));
        reset = 1'b0;

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            tgt_valid = ($urandom_range(0, 2) != 0);
            tgt_data  = W'($urandom);
            reset     = ($urandom_range(0, 99) == 0);
            if (reset) stuck0 = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
        end
        @(negedge clock);
        reset = 1'b0; tgt_valid = 1'b0;
        repeat (10) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
